// File: rtl/osc_disp_pkg.sv
// osc_disp_pkg: character codes and BCD converter state shared by the on-screen display pipeline.
package osc_disp_pkg;
    localparam int DIGIT_CODE_W = 5;
    localparam logic [4:0] CHAR_PLUS  = 5'd16;
    localparam logic [4:0] CHAR_MINUS = 5'd17;
    localparam logic [4:0] CHAR_BLANK = 5'd31;
    typedef enum logic [1:0] {IDLE, SHIFT, FINAL} bcd_state_t;
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: double-dabble correction, adds 3 to every BCD nibble that is 5 or more.
module bcd_dabble_step #(
    parameter int NUM_DIGITS = 10
) (
    input  logic [NUM_DIGITS*4-1:0] bcd_in,
    output logic [NUM_DIGITS*4-1:0] bcd_out
);
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign bcd_out[g*4+:4] = (bcd_in[g*4+:4] >= 4'd5) ? bcd_in[g*4+:4] + 4'd3 : bcd_in[g*4+:4];
    end
endmodule

// File: rtl/trig_bcd_digits.sv
// trig_bcd_digits: serial binary-to-BCD conversion of the trigger level into blanked character codes.
module trig_bcd_digits
    import osc_disp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [DATA_W-1:0]                value,
    input  logic [4:0]                       sign_code,
    output logic                             busy,
    output logic                             done,
    output logic [4:0]                       sign_out,
    output logic [NUM_DIGITS*DIGIT_CODE_W-1:0] digit_codes
);
    localparam int BCD_W   = NUM_DIGITS * 4;
    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int CODES_W = NUM_DIGITS * DIGIT_CODE_W;
    localparam logic [CODES_W-1:0] RESET_CODES = {{(NUM_DIGITS-1){CHAR_BLANK}}, 5'd0};

    // ceil(DATA_W * log10(2)) digits are needed to hold the largest magnitude
    if (NUM_DIGITS < (DATA_W * 30103 + 99999) / 100000) begin : g_param_check
        $error("trig_bcd_digits: NUM_DIGITS too small for DATA_W");
    end

    bcd_state_t           state_q, state_d;
    logic [DATA_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4:0]           sign_hold_q, sign_hold_d, sign_out_q, sign_out_d;
    logic [CODES_W-1:0]   digits_q, digits_d, fmt_codes;
    logic                 busy_q, busy_d, done_q, done_d, seen;

    bcd_dabble_step #(.NUM_DIGITS(NUM_DIGITS)) u_step (.bcd_in(bcd_q), .bcd_out(bcd_adj));

    // Digits above the most significant nonzero one are blanked; digit 0 is always shown.
    always_comb begin
        seen      = 1'b0;
        fmt_codes = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen = seen || (bcd_q[i*4+:4] != 4'd0) || (i == 0);
            fmt_codes[i*DIGIT_CODE_W+:DIGIT_CODE_W] = seen ? {1'b0, bcd_q[i*4+:4]} : CHAR_BLANK;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        sign_hold_d = sign_hold_q;
        sign_out_d  = sign_out_q;
        digits_d    = digits_q;
        if (state_q == IDLE && start) begin
            shift_d     = value;
            sign_hold_d = sign_code;
            bcd_d       = '0;
            cnt_d       = '0;
            state_d     = SHIFT;
        end else if (state_q == SHIFT) begin
            {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
            cnt_d            = cnt_q + 1'b1;
            state_d          = (cnt_q == CNT_W'(DATA_W - 1)) ? FINAL : SHIFT;
        end else if (state_q == FINAL) begin
            digits_d   = fmt_codes;
            sign_out_d = (bcd_q == '0) ? CHAR_PLUS : sign_hold_q;
            state_d    = IDLE;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_q == FINAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            sign_hold_q <= '0;
            sign_out_q  <= CHAR_PLUS;
            digits_q    <= RESET_CODES;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            sign_hold_q <= sign_hold_d;
            sign_out_q  <= sign_out_d;
            digits_q    <= digits_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sign_out    = sign_out_q;
    assign digit_codes = digits_q;
endmodule

// File: tb/tb_trig_bcd_digits.sv
// tb_trig_bcd_digits: directed conversions; a monitor checks each done pulse against a queue of expected results.
module tb_trig_bcd_digits;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = '0;
    logic [4:0]  sign_code = 5'd16;
    logic        busy, done;
    logic [4:0]  sign_out;
    logic [49:0] digit_codes;

    typedef struct {
        logic [49:0] codes;
        logic [4:0]  sign;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    trig_bcd_digits dut (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .sign_code(sign_code),
        .busy(busy), .done(done), .sign_out(sign_out), .digit_codes(digit_codes)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // '_' is a blank digit, leftmost character is digit 9
    function automatic logic [49:0] str2codes(input string s);
        logic [49:0] r;
        byte c;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            c = s[9-i];
            r[i*5+:5] = (c == "_") ? 5'd31 : 5'(c - 8'd48);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.due));
                chk("digit_codes", 64'(digit_codes), 64'(e.codes));
                chk("sign_out", 64'(sign_out), 64'(e.sign));
            end
        end
    end

    // caller is at a negedge with the DUT idle; returns just after the capture edge
    task automatic issue(input logic [31:0] v, input logic [4:0] sc, input string s, input logic [4:0] es);
        exp_t e;
        value = v;
        sign_code = sc;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.codes = str2codes(s);
        e.sign = es;
        e.due = cyc + 33;
        exp_q.push_back(e);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic convert(input logic [31:0] v, input logic [4:0] sc, input string s, input logic [4:0] es);
        @(negedge clk);
        issue(v, sc, s, es);
        wait_done(50);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_sign"}, 64'(sign_out), 64'(16));
        chk({tag, "_digits"}, 64'(digit_codes), 64'(str2codes("_________0")));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_reset_outputs("idle");

        convert(32'd204600000, 5'd17, "_204600000", 5'd17);
        convert(32'd4294967295, 5'd16, "4294967295", 5'd16);
        convert(32'd0, 5'd17, "_________0", 5'd16);
        convert(32'd20, 5'd16, "________20", 5'd16);

        // start while busy is ignored, start in the done cycle is accepted
        @(negedge clk);
        issue(32'd20, 5'd17, "________20", 5'd17);
        repeat (9) @(negedge clk);
        chk("busy_mid", 64'(busy), 64'(1));
        value = 32'd999;
        sign_code = 5'd16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(50);
        issue(32'd999, 5'd16, "_______999", 5'd16);
        wait_done(50);

        // reset during a conversion abandons it without a done pulse
        @(negedge clk);
        value = 32'd55;
        sign_code = 5'd17;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk_reset_outputs("post_reset");
        convert(32'd7, 5'd16, "_________7", 5'd16);

        repeat (5) @(negedge clk);
        chk("pending_results", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
